// File: rtl/sa_ws_tile.sv
// Weight-stationary HEIGHT x WIDTH systolic tile: weight-row preload, ifm skew, ofm deskew, valid/ready.
// States: IDLE/LOAD accept weight rows, STREAM accepts ifm vectors, DRAIN flushes until ofm_last.
module sa_ws_tile #(
  parameter int HEIGHT = 8,
  parameter int WIDTH  = 8,
  parameter int IWIDTH = 16,
  parameter int OWIDTH = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          wght_valid_i,
  output logic                          wght_ready_o,
  input  logic [WIDTH-1:0][IWIDTH-1:0]  wght_i,
  input  logic                          ifm_valid_i,
  output logic                          ifm_ready_o,
  input  logic [HEIGHT-1:0][IWIDTH-1:0] ifm_i,
  input  logic                          ifm_last_i,
  output logic                          ofm_valid_o,
  output logic [WIDTH-1:0][OWIDTH-1:0]  ofm_o,
  output logic                          ofm_last_o,
  output logic                          busy_o
);

  localparam int L  = HEIGHT + WIDTH;
  localparam int CW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DRAIN} state_e;

  state_e                          state_q, state_d;
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic                            rdy_q;
  logic [CW-1:0]                   wr_row;
  logic                            wr_en, ifm_acc;
  logic [L-1:0]                    vld_q, last_q;
  logic [WIDTH-1:0][OWIDTH-1:0]    ofm_q;
  logic [IWIDTH-1:0]               w_q [HEIGHT][WIDTH];
  logic [HEIGHT-1:0][IWIDTH-1:0]   ifm_g, a_col0;
  logic [IWIDTH-1:0]               a_pe [HEIGHT][WIDTH];
  logic [OWIDTH-1:0]               ps_pe [HEIGHT][WIDTH];
  logic [WIDTH-1:0][OWIDTH-1:0]    col_out;

  // rdy_q keeps wght_ready low until the first edge after reset release
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wght_ready_o = 1'b0;
    ifm_ready_o  = 1'b0;
    case (state_q)
      IDLE: begin
        wght_ready_o = rdy_q;
        if (wght_valid_i && rdy_q) begin
          cnt_d   = CW'(1);
          state_d = (HEIGHT == 1) ? STREAM : LOAD;
        end
      end
      LOAD: begin
        wght_ready_o = 1'b1;
        if (wght_valid_i) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(HEIGHT - 1)) state_d = STREAM;
        end
      end
      STREAM: begin
        ifm_ready_o = 1'b1;
        if (ifm_valid_i && ifm_last_i) state_d = DRAIN;
      end
      DRAIN: begin
        if (ofm_last_o) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_row  = (state_q == IDLE) ? '0 : cnt_q;
  assign wr_en   = wght_valid_i && wght_ready_o;
  assign ifm_acc = ifm_valid_i && ifm_ready_o;
  assign busy_o  = (state_q != IDLE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int h = 0; h < HEIGHT; h++)
        for (int w = 0; w < WIDTH; w++) w_q[h][w] <= '0;
    end else if (wr_en) begin
      for (int h = 0; h < HEIGHT; h++)
        if (wr_row == CW'(h))
          for (int w = 0; w < WIDTH; w++) w_q[h][w] <= wght_i[w];
    end
  end

  // Bubble lanes carry zeros so idle data never toggles the array
  assign ifm_g     = ifm_acc ? ifm_i : '0;
  assign a_col0[0] = ifm_g[0];

  for (genvar h = 1; h < HEIGHT; h++) begin : g_skew
    logic [IWIDTH-1:0] sk_q [h];
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        for (int i = 0; i < h; i++) sk_q[i] <= '0;
      end else begin
        sk_q[0] <= ifm_g[h];
        for (int i = 1; i < h; i++) sk_q[i] <= sk_q[i-1];
      end
    end
    assign a_col0[h] = sk_q[h-1];
  end

  for (genvar h = 0; h < HEIGHT; h++) begin : g_row
    for (genvar w = 0; w < WIDTH; w++) begin : g_col
      logic [IWIDTH-1:0]          a_in, a_q;
      logic [OWIDTH-1:0]          ps_in, ps_d, ps_q;
      logic signed [2*IWIDTH-1:0] prod;
      if (w == 0) begin : g_a0
        assign a_in = a_col0[h];
      end else begin : g_an
        assign a_in = a_pe[h][w-1];
      end
      if (h == 0) begin : g_p0
        assign ps_in = '0;
      end else begin : g_pn
        assign ps_in = ps_pe[h-1][w];
      end
      assign prod = (2*IWIDTH)'($signed(a_in)) * (2*IWIDTH)'($signed(w_q[h][w]));
      assign ps_d = ps_in + OWIDTH'(prod);
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          a_q  <= '0;
          ps_q <= '0;
        end else begin
          a_q  <= a_in;
          ps_q <= ps_d;
        end
      end
      assign a_pe[h][w]  = a_q;
      assign ps_pe[h][w] = ps_q;
    end
  end

  for (genvar w = 0; w < WIDTH; w++) begin : g_dsk
    localparam int D = WIDTH - 1 - w;
    if (D == 0) begin : g_d0
      assign col_out[w] = ps_pe[HEIGHT-1][w];
    end else begin : g_dn
      logic [OWIDTH-1:0] dk_q [D];
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          for (int i = 0; i < D; i++) dk_q[i] <= '0;
        end else begin
          dk_q[0] <= ps_pe[HEIGHT-1][w];
          for (int i = 1; i < D; i++) dk_q[i] <= dk_q[i-1];
        end
      end
      assign col_out[w] = dk_q[D-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_q  <= '0;
      last_q <= '0;
      ofm_q  <= '0;
    end else begin
      vld_q  <= {vld_q[L-2:0], ifm_acc};
      last_q <= {last_q[L-2:0], ifm_acc & ifm_last_i};
      if (vld_q[L-2]) ofm_q <= col_out;
    end
  end

  assign ofm_valid_o = vld_q[L-1];
  assign ofm_last_o  = last_q[L-1];
  assign ofm_o       = ofm_q;

endmodule

// File: tb/tb_sa_ws_tile.sv
// Bench for sa_ws_tile: 4x4, default 8x8 and 1x3 instances, scoreboard keyed by due cycle.
module tb_sa_ws_tile;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic wv_a = 0, wr_a, iv_a = 0, ir_a, il_a = 0, ov_a, ol_a, busy_a;
  logic [3:0][15:0] wg_a = '0, ifm_a = '0;
  logic [3:0][31:0] ofm_a;
  logic wv_b = 0, wr_b, iv_b = 0, ir_b, il_b = 0, ov_b, ol_b, busy_b;
  logic [7:0][15:0] wg_b = '0, ifm_b = '0;
  logic [7:0][31:0] ofm_b;
  logic wv_c = 0, wr_c, iv_c = 0, ir_c, il_c = 0, ov_c, ol_c, busy_c;
  logic [2:0][15:0] wg_c = '0;
  logic [0:0][15:0] ifm_c = '0;
  logic [2:0][31:0] ofm_c;

  sa_ws_tile #(.HEIGHT(4), .WIDTH(4), .IWIDTH(16), .OWIDTH(32)) u_a (
    .clk_i(clk), .rst_n_i(rst_n), .wght_valid_i(wv_a), .wght_ready_o(wr_a), .wght_i(wg_a),
    .ifm_valid_i(iv_a), .ifm_ready_o(ir_a), .ifm_i(ifm_a), .ifm_last_i(il_a),
    .ofm_valid_o(ov_a), .ofm_o(ofm_a), .ofm_last_o(ol_a), .busy_o(busy_a));
  sa_ws_tile u_b (
    .clk_i(clk), .rst_n_i(rst_n), .wght_valid_i(wv_b), .wght_ready_o(wr_b), .wght_i(wg_b),
    .ifm_valid_i(iv_b), .ifm_ready_o(ir_b), .ifm_i(ifm_b), .ifm_last_i(il_b),
    .ofm_valid_o(ov_b), .ofm_o(ofm_b), .ofm_last_o(ol_b), .busy_o(busy_b));
  sa_ws_tile #(.HEIGHT(1), .WIDTH(3), .IWIDTH(16), .OWIDTH(32)) u_c (
    .clk_i(clk), .rst_n_i(rst_n), .wght_valid_i(wv_c), .wght_ready_o(wr_c), .wght_i(wg_c),
    .ifm_valid_i(iv_c), .ifm_ready_o(ir_c), .ifm_i(ifm_c), .ifm_last_i(il_c),
    .ofm_valid_o(ov_c), .ofm_o(ofm_c), .ofm_last_o(ol_c), .busy_o(busy_c));

  typedef struct {
    logic [7:0][31:0] ofm;
    logic             last;
    int               due;
  } exp_t;

  exp_t q [3][$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   lat [3] = '{8, 16, 4};
  logic ov [3];
  logic ol [3];
  logic [7:0][31:0] oa [3];
  int   wm_a [4][4];
  int   wm_b [8][8];
  int   wm_c [3];

  assign ov[0] = ov_a;  assign ol[0] = ol_a;  assign oa[0] = 256'(ofm_a);
  assign ov[1] = ov_b;  assign ol[1] = ol_b;  assign oa[1] = 256'(ofm_b);
  assign ov[2] = ov_c;  assign ol[2] = ol_c;  assign oa[2] = 256'(ofm_c);

  function automatic logic [7:0][31:0] mdl_a(input logic [3:0][15:0] v);
    logic [7:0][31:0] r = '0;
    longint s;
    for (int w = 0; w < 4; w++) begin
      s = 0;
      for (int h = 0; h < 4; h++) s += longint'($signed(v[h])) * wm_a[h][w];
      r[w] = s[31:0];
    end
    return r;
  endfunction

  function automatic logic [7:0][31:0] mdl_b(input logic [7:0][15:0] v);
    logic [7:0][31:0] r = '0;
    longint s;
    for (int w = 0; w < 8; w++) begin
      s = 0;
      for (int h = 0; h < 8; h++) s += longint'($signed(v[h])) * wm_b[h][w];
      r[w] = s[31:0];
    end
    return r;
  endfunction

  function automatic logic [7:0][31:0] mdl_c(input logic [15:0] x);
    logic [7:0][31:0] r = '0;
    longint s;
    for (int w = 0; w < 3; w++) begin
      s = longint'($signed(x)) * wm_c[w];
      r[w] = s[31:0];
    end
    return r;
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (ov[d] === 1'b1) begin
          n_vec++;
          if (q[d].size() == 0) begin
            n_err++;
            $display("FAIL ofm%0d_extra: got ofm_valid=1 at cycle %0d, required 0", d, cyc);
          end else begin
            e = q[d].pop_front();
            if (oa[d] !== e.ofm || ol[d] !== e.last || cyc != e.due) begin
              n_err++;
              $display("FAIL ofm%0d_result: got ofm=%h last=%b cycle=%0d, required ofm=%h last=%b cycle=%0d",
                       d, oa[d], ol[d], cyc, e.ofm, e.last, e.due);
            end
          end
        end else if (q[d].size() > 0 && cyc > q[d][0].due) begin
          n_vec++;
          n_err++;
          e = q[d].pop_front();
          $display("FAIL ofm%0d_missing: got ofm_valid=%b at cycle %0d, required 1 at cycle %0d", d, ov[d], cyc, e.due);
        end
      end
    end
  endtask

  task automatic wbeat_a(input logic [3:0][15:0] row);
    wv_a = 1'b1; wg_a = row;
    for (int i = 0; i < 20 && wr_a !== 1'b1; i++) @(negedge clk);
    n_vec++;
    if (wr_a !== 1'b1) begin n_err++; $display("FAIL wght_ready_a: got %b, required 1", wr_a); end
    @(negedge clk);
    wv_a = 1'b0;
  endtask

  task automatic load_a(input int stall_at, input int stall_n);
    logic [3:0][15:0] row;
    for (int k = 0; k < 4; k++) begin
      if (k == stall_at) begin
        iv_a = 1'b1; ifm_a = {4{16'h0101}};
        for (int s = 0; s < stall_n; s++) begin
          n_vec++;
          if (busy_a !== 1'b1 || wr_a !== 1'b1 || ir_a !== 1'b0) begin
            n_err++;
            $display("FAIL load_stall: got busy=%b wght_ready=%b ifm_ready=%b, required 1 1 0", busy_a, wr_a, ir_a);
          end
          @(negedge clk);
        end
        iv_a = 1'b0;
      end
      for (int w = 0; w < 4; w++) row[w] = 16'(wm_a[k][w]);
      wbeat_a(row);
    end
  endtask

  task automatic send_a(input logic [3:0][15:0] v, input logic last);
    exp_t e;
    iv_a = 1'b1; ifm_a = v; il_a = last;
    for (int i = 0; i < 20 && ir_a !== 1'b1; i++) @(negedge clk);
    n_vec++;
    if (ir_a !== 1'b1) begin
      n_err++; $display("FAIL ifm_ready_a: got %b, required 1", ir_a);
    end else begin
      e.ofm = mdl_a(v); e.last = last; e.due = cyc + lat[0];
      q[0].push_back(e);
    end
    @(negedge clk);
    iv_a = 1'b0; il_a = 1'b0;
  endtask

  task automatic end_batch_a();
    for (int i = 0; i < 40 && busy_a !== 1'b0; i++) @(negedge clk);
    n_vec++;
    if (busy_a !== 1'b0 || wr_a !== 1'b1 || q[0].size() != 0) begin
      n_err++;
      $display("FAIL batch_end_a: got busy=%b wght_ready=%b pending=%0d, required 0 1 0", busy_a, wr_a, q[0].size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_vec++;
    if ({wr_a, ir_a, ov_a, ol_a, busy_a} !== 5'b0 || ofm_a !== '0) begin
      n_err++;
      $display("FAIL reset_a: got rdy/irdy/ov/ol/busy=%b ofm=%h, required 00000 0", {wr_a, ir_a, ov_a, ol_a, busy_a}, ofm_a);
    end
    n_vec++;
    if (wr_b !== 1'b0 || wr_c !== 1'b0 || busy_b !== 1'b0 || busy_c !== 1'b0) begin
      n_err++; $display("FAIL reset_bc: got wr_b=%b wr_c=%b busy_b=%b busy_c=%b, required 0", wr_b, wr_c, busy_b, busy_c);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (wr_a !== 1'b1 || ir_a !== 1'b0 || busy_a !== 1'b0) begin
      n_err++; $display("FAIL idle_a: got wght_ready=%b ifm_ready=%b busy=%b, required 1 0 0", wr_a, ir_a, busy_a);
    end
  endtask

  task automatic test_identity();
    logic [3:0][15:0] v;
    for (int h = 0; h < 4; h++) for (int w = 0; w < 4; w++) wm_a[h][w] = (h == w) ? 1 : 0;
    load_a(-1, 0);
    n_vec++;
    if (ir_a !== 1'b1 || wr_a !== 1'b0 || busy_a !== 1'b1) begin
      n_err++; $display("FAIL stream_entry: got ifm_ready=%b wght_ready=%b busy=%b, required 1 0 1", ir_a, wr_a, busy_a);
    end
    for (int h = 0; h < 4; h++) v[h] = 16'(h + 1);
    send_a(v, 1'b1);
    for (int i = 0; i < 20 && ol_a !== 1'b1; i++) @(negedge clk);
    n_vec++;
    if (ol_a !== 1'b1 || busy_a !== 1'b1) begin
      n_err++; $display("FAIL drain_hold: got ofm_last=%b busy=%b, required 1 1", ol_a, busy_a);
    end
    @(negedge clk);
    n_vec++;
    if (busy_a !== 1'b0) begin n_err++; $display("FAIL busy_fall: got %b, required 0", busy_a); end
    end_batch_a();
  endtask

  task automatic test_throughput();
    logic [3:0][15:0] v;
    for (int h = 0; h < 4; h++) for (int w = 0; w < 4; w++) wm_a[h][w] = h + 1;
    load_a(-1, 0);
    for (int n = 0; n < 16; n++) begin
      for (int h = 0; h < 4; h++) v[h] = 16'(n);
      send_a(v, n == 15);
    end
    end_batch_a();
  endtask

  task automatic test_bubbles();
    logic [3:0][15:0] v;
    logic [15:0] r;
    for (int h = 0; h < 4; h++)
      for (int w = 0; w < 4; w++) begin r = 16'($urandom); wm_a[h][w] = $signed(r); end
    load_a(2, 3);
    for (int h = 0; h < 4; h++) v[h] = 16'($urandom);
    send_a(v, 1'b0);
    wv_a = 1'b1; wg_a = {4{16'h7FFF}};
    for (int b = 0; b < 2; b++) begin
      n_vec++;
      if (wr_a !== 1'b0) begin n_err++; $display("FAIL stream_wready: got %b, required 0", wr_a); end
      @(negedge clk);
    end
    for (int h = 0; h < 4; h++) v[h] = 16'($urandom);
    send_a(v, 1'b0);
    for (int h = 0; h < 4; h++) v[h] = 16'($urandom);
    send_a(v, 1'b1);
    n_vec++;
    if (wr_a !== 1'b0 || ir_a !== 1'b0 || busy_a !== 1'b1) begin
      n_err++; $display("FAIL drain_ready: got wght_ready=%b ifm_ready=%b busy=%b, required 0 0 1", wr_a, ir_a, busy_a);
    end
    @(negedge clk);
    wv_a = 1'b0;
    end_batch_a();
  endtask

  task automatic test_reset_drain();
    logic [3:0][15:0] v;
    logic seen;
    for (int h = 0; h < 4; h++) for (int w = 0; w < 4; w++) wm_a[h][w] = (h == w) ? 1 : 0;
    load_a(-1, 0);
    for (int h = 0; h < 4; h++) v[h] = 16'($urandom);
    send_a(v, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    q[0].delete();
    @(negedge clk);
    n_vec++;
    if (busy_a !== 1'b0 || ov_a !== 1'b0 || wr_a !== 1'b0 || ofm_a !== '0) begin
      n_err++; $display("FAIL reset_mid: got busy=%b ofm_valid=%b wght_ready=%b ofm=%h, required 0 0 0 0", busy_a, ov_a, wr_a, ofm_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin @(negedge clk); if (ov_a !== 1'b0) seen = 1'b1; end
    n_vec++;
    if (seen) begin n_err++; $display("FAIL post_reset_valid: got ofm_valid=1, required none"); end
    load_a(-1, 0);
    for (int h = 0; h < 4; h++) v[h] = 16'($urandom);
    send_a(v, 1'b1);
    end_batch_a();
  endtask

  task automatic test_signed_b();
    logic [7:0][15:0] v;
    exp_t e;
    for (int h = 0; h < 8; h++) for (int w = 0; w < 8; w++) wm_b[h][w] = -32768;
    for (int k = 0; k < 8; k++) begin
      wv_b = 1'b1; wg_b = {8{16'h8000}};
      for (int i = 0; i < 20 && wr_b !== 1'b1; i++) @(negedge clk);
      n_vec++;
      if (wr_b !== 1'b1) begin n_err++; $display("FAIL wght_ready_b: got %b, required 1", wr_b); end
      @(negedge clk);
    end
    wv_b = 1'b0;
    for (int n = 0; n < 2; n++) begin
      v = (n == 0) ? {8{16'h8000}} : {8{16'h7FFF}};
      iv_b = 1'b1; ifm_b = v; il_b = (n == 1);
      for (int i = 0; i < 20 && ir_b !== 1'b1; i++) @(negedge clk);
      n_vec++;
      if (ir_b !== 1'b1) begin
        n_err++; $display("FAIL ifm_ready_b: got %b, required 1", ir_b);
      end else begin
        e.ofm = mdl_b(v); e.last = (n == 1); e.due = cyc + lat[1];
        q[1].push_back(e);
      end
      @(negedge clk);
    end
    iv_b = 1'b0; il_b = 1'b0;
    for (int i = 0; i < 60 && busy_b !== 1'b0; i++) @(negedge clk);
    n_vec++;
    if (busy_b !== 1'b0 || q[1].size() != 0) begin
      n_err++; $display("FAIL batch_end_b: got busy=%b pending=%0d, required 0 0", busy_b, q[1].size());
    end
  endtask

  task automatic test_degenerate_c();
    logic [15:0] x;
    exp_t e;
    wm_c[0] = 5; wm_c[1] = -7; wm_c[2] = 32767;
    wv_c = 1'b1; wg_c = {16'h7FFF, 16'hFFF9, 16'h0005};
    for (int i = 0; i < 20 && wr_c !== 1'b1; i++) @(negedge clk);
    @(negedge clk);
    wv_c = 1'b0;
    n_vec++;
    if (ir_c !== 1'b1 || wr_c !== 1'b0 || busy_c !== 1'b1) begin
      n_err++; $display("FAIL c_direct_stream: got ifm_ready=%b wght_ready=%b busy=%b, required 1 0 1", ir_c, wr_c, busy_c);
    end
    for (int n = 0; n < 3; n++) begin
      x = (n == 0) ? 16'h8000 : 16'($urandom);
      iv_c = 1'b1; ifm_c[0] = x; il_c = (n == 2);
      n_vec++;
      if (ir_c !== 1'b1) begin
        n_err++; $display("FAIL ifm_ready_c: got %b, required 1", ir_c);
      end else begin
        e.ofm = mdl_c(x); e.last = (n == 2); e.due = cyc + lat[2];
        q[2].push_back(e);
      end
      @(negedge clk);
    end
    iv_c = 1'b0; il_c = 1'b0;
    for (int i = 0; i < 30 && busy_c !== 1'b0; i++) @(negedge clk);
    n_vec++;
    if (busy_c !== 1'b0 || q[2].size() != 0) begin
      n_err++; $display("FAIL batch_end_c: got busy=%b pending=%0d, required 0 0", busy_c, q[2].size());
    end
  endtask

  initial begin
    fork
      forever begin @(posedge clk); cyc++; end
      monitor();
      begin
        #400000;
        $display("FAIL watchdog: got no completion by cycle %0d, required completion", cyc);
        $fatal(1);
      end
    join_none
    test_reset();
    test_identity();
    test_throughput();
    test_bubbles();
    test_reset_drain();
    test_signed_b();
    test_degenerate_c();
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
